calc_checker: RTL
=================

CALC_CHECKER -- requirements
Module: calc_checker

Interface
REQ-001 Parameter: SETTLE, 1, clock edges (1..15) between driving operands onto the calculator pins and sampling out_n.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: clear  input  1  synchronous; zeroes counters and leaves DONE.
REQ-005 Port: in_valid  input  1  command valid.
REQ-006 Port: in_ready  output  1  command accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 Port: cmd_n0, cmd_n1  input  3 each  unsigned operands.
REQ-008 Port: cmd_opt  input  2  00 add, 01 sub, 10 mul, 11 reserved.
REQ-009 Port: cmd_last  input  1  marks final vector of a run.
REQ-010 Port: in_n0, in_n1, opt  output  3/3/2  registered drive into the calculator core.
REQ-011 Port: out_n  input  7  calculator result.
REQ-012 Port: res_valid  output  1  one-cycle result strobe.
REQ-013 Port: res_data  output  7  sampled out_n.
REQ-014 Port: res_pass  output  1  sampled out_n equals golden value.
REQ-015 Port: err_cnt, vec_cnt  output  8 each  mismatch and vector counts, saturating at 255.
REQ-016 Port: done  output  1  high after the cmd_last vector is checked.

Function
REQ-017 FSM states: IDLE, WAIT, REPORT, DONE. in_ready is high only in IDLE.
REQ-018 On acceptance in IDLE, register the cmd fields onto in_n0/in_n1/opt at the same edge, load the settle counter with SETTLE-1, and enter WAIT.
REQ-019 In WAIT, decrement the counter each edge. At the edge where the counter is 0, sample out_n into res_data, compute res_pass, and enter REPORT.
REQ-020 In REPORT, hold res_valid high for exactly one cycle.
REQ-021 At the REPORT-exit edge: increment vec_cnt; increment err_cnt if !res_pass.
REQ-022 At the REPORT-exit edge: go to DONE if the accepted command's cmd_last was 1, else to IDLE.
REQ-023 Latency: acceptance at edge E gives res_valid high in the cycle after edge E+SETTLE. The next acceptance is possible no earlier than edge E+SETTLE+2.
REQ-024 Golden value, all results 7-bit:
- add: n0+n1.
- sub: (n0-n1) mod 128 (two's complement).
- mul: n0*n1.
- reserved: 0.
REQ-025 in_n0/in_n1/opt hold their last driven value until the next acceptance.
REQ-026 DONE: done=1, in_ready=0; exits to IDLE only on clear.
REQ-027 clear in any state zeroes both counters and sets done=0. In DONE, clear also moves the FSM to IDLE. clear has priority over the REPORT-exit counter update in the same cycle.
REQ-028 Counters saturate at 255 and never wrap.
REQ-029 in_valid while in_ready=0 is ignored; the command is not queued.

Reset
REQ-030 rst asserted forces, immediately and regardless of clk: state=IDLE; in_n0/in_n1/opt=0; res_valid=0; res_data=0; res_pass=0; err_cnt=0; vec_cnt=0; done=0.
REQ-031 rst asserted mid-WAIT or mid-REPORT discards the vector: no result strobe, no count update.
REQ-032 in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-033 Macro CALC_CHECKER_GOLDEN_EN: when defined, golden compare per REQ-024 drives res_pass and err_cnt.
REQ-034 When CALC_CHECKER_GOLDEN_EN is undefined: no golden logic is built, res_pass is tied to 1, and err_cnt is tied to 0. Timing and all other outputs are unchanged.

Structure
REQ-035 Shared package calc_pkg holds the opt encodings, the FSM state enum, and the width constants for operands (3), opt (2) and result (7).
REQ-036 The golden model is a combinational sub-module, calc_golden (n0, n1, opt -> 7-bit result), instantiated only under CALC_CHECKER_GOLDEN_EN.

Verification
REQ-037 SETTLE=1, correct core, add 5+6 -> res_valid in the cycle after edge E+1; res_data=11; res_pass=1; vec_cnt=1.
REQ-038 Correct core, sub 2-7 -> res_data=7'h7B; res_pass=1. Mul 7*7 -> res_data=49.
REQ-039 Faulty core returning 0 for mul 3*3 -> res_pass=0; err_cnt=1; next vector still accepted.
REQ-040 Three vectors with cmd_last on the third -> done=1, in_ready=0, vec_cnt=3. Further in_valid is ignored. A clear pulse -> IDLE, counters 0.
REQ-041 SETTLE=4, rst pulsed during WAIT -> no res_valid, all outputs 0, in_ready=1 after release.
REQ-042 260 mismatching vectors -> err_cnt=255 and vec_cnt=255, held with no wrap.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator checker.
// Imported by calc_golden and calc_checker.
package calc_pkg;

  localparam int N_W   = 3;
  localparam int OPT_W = 2;
  localparam int RES_W = 7;
  localparam int CNT_W = 8;
  localparam int SET_W = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [OPT_W-1:0] {
    OPT_ADD  = 2'b00,
    OPT_SUB  = 2'b01,
    OPT_MUL  = 2'b10,
    OPT_RSVD = 2'b11
  } opt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_REPORT,
    ST_DONE
  } state_e;

  // Counters stick at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/calc_golden.sv
// Combinational golden model of the calculator core.
// All results are truncated to RES_W bits.
module calc_golden
  import calc_pkg::*;
(
  input  logic [N_W-1:0]   n0,
  input  logic [N_W-1:0]   n1,
  input  logic [OPT_W-1:0] opt,
  output logic [RES_W-1:0] result
);

  always_comb begin
    result = '0;
    case (opt)
      OPT_ADD: result = RES_W'(n0) + RES_W'(n1);
      OPT_SUB: result = RES_W'(n0) - RES_W'(n1);
      OPT_MUL: result = RES_W'(n0) * RES_W'(n1);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/calc_checker.sv
// Drives one vector at a time into a calculator core, samples its result
// after SETTLE edges and keeps pass/vector counts. Golden compare is built
// only when CALC_CHECKER_GOLDEN_EN is defined.
module calc_checker
  import calc_pkg::*;
#(
  parameter int SETTLE = 1
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_W-1:0]   cmd_n0,
  input  logic [N_W-1:0]   cmd_n1,
  input  logic [OPT_W-1:0] cmd_opt,
  input  logic             cmd_last,
  output logic [N_W-1:0]   in_n0,
  output logic [N_W-1:0]   in_n1,
  output logic [OPT_W-1:0] opt,
  input  logic [RES_W-1:0] out_n,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  output logic             res_pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             done
);

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [N_W-1:0]     n0_q, n0_d, n1_q, n1_d;
  logic [OPT_W-1:0]   opt_q, opt_d;
  logic               last_q, last_d;
  logic [RES_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   vec_q, vec_d;

  logic accept;
  logic sample;
  logic report_exit;

  assign accept      = in_valid && in_ready;
  assign sample      = (state_q == ST_WAIT) && (settle_q == '0);
  assign report_exit = (state_q == ST_REPORT);

  // NOTE: async reset lives in the sensitivity list; every register gets a reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: combinational blocks assign defaults first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_WAIT;
      ST_WAIT:   if (settle_q == '0) state_d = ST_REPORT;
      ST_REPORT: state_d = last_q ? ST_DONE : ST_IDLE;
      ST_DONE:   if (clear) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    res_valid = (state_q == ST_REPORT);
    done      = (state_q == ST_DONE);
  end

  always_comb begin
    settle_d = settle_q;
    n0_d     = n0_q;
    n1_d     = n1_q;
    opt_d    = opt_q;
    last_d   = last_q;
    data_d   = data_q;
    vec_d    = vec_q;
    if (accept) begin
      n0_d     = cmd_n0;
      n1_d     = cmd_n1;
      opt_d    = cmd_opt;
      last_d   = cmd_last;
      settle_d = SET_W'(SETTLE - 1);
    end else if ((state_q == ST_WAIT) && (settle_q != '0)) begin
      settle_d = settle_q - SET_W'(1);
    end
    if (sample) data_d = out_n;
    // clear wins over the REPORT-exit increment landing on the same edge.
    if (clear)            vec_d = '0;
    else if (report_exit) vec_d = sat_inc(vec_q);
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q <= '0;
      n0_q     <= '0;
      n1_q     <= '0;
      opt_q    <= '0;
      last_q   <= 1'b0;
      data_q   <= '0;
      vec_q    <= '0;
    end else begin
      settle_q <= settle_d;
      n0_q     <= n0_d;
      n1_q     <= n1_d;
      opt_q    <= opt_d;
      last_q   <= last_d;
      data_q   <= data_d;
      vec_q    <= vec_d;
    end
  end

  assign in_n0    = n0_q;
  assign in_n1    = n1_q;
  assign opt      = opt_q;
  assign res_data = data_q;
  assign vec_cnt  = vec_q;

`ifdef CALC_CHECKER_GOLDEN_EN
  logic [RES_W-1:0] golden;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] err_q, err_d;

  calc_golden u_golden (
    .n0     (n0_q),
    .n1     (n1_q),
    .opt    (opt_q),
    .result (golden)
  );

  always_comb begin
    pass_d = pass_q;
    err_d  = err_q;
    if (sample) pass_d = (out_n == golden);
    if (clear)                       err_d = '0;
    else if (report_exit && !pass_q) err_d = sat_inc(err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
      err_q  <= '0;
    end else begin
      pass_q <= pass_d;
      err_q  <= err_d;
    end
  end

  assign res_pass = pass_q;
  assign err_cnt  = err_q;
`else
  assign res_pass = 1'b1;
  assign err_cnt  = '0;
`endif

endmodule
